// File: rtl/dpram_init_pkg.sv
// Shared types for the dual-port RAM initiator: FSM state, registered
// command and response payloads, and the write-collision predicate.
package dpram_init_pkg;

  localparam int AW = 8;
  localparam int DW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ISSUE,
    S_RD_ISSUE,
    S_RD_CAPT,
    S_RD_RECOVER,
    S_RSP
  } state_t;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] wdata_a;
    logic [DW-1:0] wdata_b;
  } cmd_t;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata_a;
    logic [DW-1:0] rdata_b;
  } rsp_t;

  // Same address on both ports with different data would leave the RAM
  // content dependent on port priority.
  function automatic logic is_collision(cmd_t c);
    return c.wr && (c.addr_a == c.addr_b) && (c.wdata_a != c.wdata_b);
  endfunction

endpackage

// File: rtl/dpram_initiator_if.sv
// Command/response handshake bundle between a requester (master) and the
// dual-port RAM initiator (slave).
interface dpram_initiator_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_wr;
  logic [ADDR_WIDTH-1:0] cmd_addr_a;
  logic [ADDR_WIDTH-1:0] cmd_addr_b;
  logic [DATA_WIDTH-1:0] cmd_wdata_a;
  logic [DATA_WIDTH-1:0] cmd_wdata_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata_a;
  logic [DATA_WIDTH-1:0] rsp_rdata_b;
  logic                  rsp_err;

  modport master (
    output cmd_valid, cmd_wr, cmd_addr_a, cmd_addr_b, cmd_wdata_a, cmd_wdata_b,
    output rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata_a, rsp_rdata_b, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr_a, cmd_addr_b, cmd_wdata_a, cmd_wdata_b,
    input  rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata_a, rsp_rdata_b, rsp_err
  );
endinterface

// File: rtl/dpram_rdy_timer.sv
// Counts cycles while enabled; pulses timeout_o in the cycle whose count
// reaches TIMEOUT. clr_i restarts the count from zero.
module dpram_rdy_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and saturate at TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != CW'(TIMEOUT)))
      cnt_d = cnt_q + CW'(1);
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign timeout_o = en_i && (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/dpram_initiator.sv
// Requester-side engine for the dual-port RAM sel/wr/ready interface.
// One command in flight; exactly one response per accepted command.
// Reads hold sel through the RAM's ready-low recovery cycle.
// Optional: DPRAM_INIT_COLLIDE_CHK_EN rejects writes that hit the same
// address on both ports with different data (error response, no RAM access).
//
// state        | meaning
// S_IDLE       | cmd_ready=1, waiting for a command
// S_WR_ISSUE   | sel=1 wr=1, waiting for ram_ready to commit
// S_RD_ISSUE   | sel=1 wr=0, waiting for ram_ready
// S_RD_CAPT    | sel held, rdata captured at the closing edge
// S_RD_RECOVER | sel=0, waiting for ram_ready to come back
// S_RSP        | rsp_valid=1 until rsp_ready
module dpram_initiator
  import dpram_init_pkg::*;
#(
  parameter int ADDR_WIDTH = AW,
  parameter int DATA_WIDTH = DW,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  dpram_initiator_if.slave      cmd_if,
  output logic                  ram_sel_o,
  output logic                  ram_wr_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_a_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_b_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_a_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_b_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_a_i,
  input  logic [DATA_WIDTH-1:0] ram_rdata_b_i,
  input  logic                  ram_ready_i
);
  state_t state_q, state_d;
  cmd_t   cmd_q, cmd_d, cmd_in;
  rsp_t   rsp_q, rsp_d;
  logic   collide;
  logic   tmr_clr, tmr_en, tmr_expired;

  assign cmd_in = '{wr:      cmd_if.cmd_wr,
                    addr_a:  cmd_if.cmd_addr_a,
                    addr_b:  cmd_if.cmd_addr_b,
                    wdata_a: cmd_if.cmd_wdata_a,
                    wdata_b: cmd_if.cmd_wdata_b};

`ifdef DPRAM_INIT_COLLIDE_CHK_EN
  assign collide = is_collision(cmd_in);
`else
  assign collide = 1'b0;
`endif

  // State, registered command and response payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rsp_q   <= rsp_d;
    end
  end

  // Next-state logic and RAM control strobes.
  always_comb begin
    state_d          = state_q;
    cmd_d            = cmd_q;
    rsp_d            = rsp_q;
    ram_sel_o        = 1'b0;
    ram_wr_o         = 1'b0;
    tmr_en           = 1'b0;
    cmd_if.rsp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_if.cmd_valid) begin
          cmd_d = cmd_in;
          rsp_d = '0;
          if (collide) begin
            rsp_d.err = 1'b1;
            state_d   = S_RSP;
          end else if (cmd_if.cmd_wr) begin
            state_d = S_WR_ISSUE;
          end else begin
            state_d = S_RD_ISSUE;
          end
        end
      end
      S_WR_ISSUE: begin
        ram_sel_o = 1'b1;
        ram_wr_o  = 1'b1;
        tmr_en    = !ram_ready_i;
        if (ram_ready_i) begin
          state_d = S_RSP;
        end else if (tmr_expired) begin
          rsp_d     = '0;
          rsp_d.err = 1'b1;
          state_d   = S_RSP;
        end
      end
      S_RD_ISSUE: begin
        ram_sel_o = 1'b1;
        tmr_en    = !ram_ready_i;
        if (ram_ready_i) begin
          state_d = S_RD_CAPT;
        end else if (tmr_expired) begin
          rsp_d     = '0;
          rsp_d.err = 1'b1;
          state_d   = S_RSP;
        end
      end
      S_RD_CAPT: begin
        ram_sel_o     = 1'b1;
        rsp_d.rdata_a = ram_rdata_a_i;
        rsp_d.rdata_b = ram_rdata_b_i;
        state_d       = S_RD_RECOVER;
      end
      S_RD_RECOVER: begin
        tmr_en = !ram_ready_i;
        if (ram_ready_i) begin
          state_d = S_RSP;
        end else if (tmr_expired) begin
          rsp_d     = '0;
          rsp_d.err = 1'b1;
          state_d   = S_RSP;
        end
      end
      S_RSP: begin
        cmd_if.rsp_valid = 1'b1;
        if (cmd_if.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tmr_clr = (state_d != state_q);

  dpram_rdy_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .timeout_o (tmr_expired)
  );

  assign cmd_if.cmd_ready   = (state_q == S_IDLE) && !rst;
  assign cmd_if.rsp_rdata_a = rsp_q.rdata_a;
  assign cmd_if.rsp_rdata_b = rsp_q.rdata_b;
  assign cmd_if.rsp_err     = rsp_q.err;

  // RAM address/data come only from the registered command, parked at 0 in IDLE.
  assign ram_addr_a_o  = (state_q == S_IDLE) ? '0 : cmd_q.addr_a;
  assign ram_addr_b_o  = (state_q == S_IDLE) ? '0 : cmd_q.addr_b;
  assign ram_wdata_a_o = (state_q == S_IDLE) ? '0 : cmd_q.wdata_a;
  assign ram_wdata_b_o = (state_q == S_IDLE) ? '0 : cmd_q.wdata_b;
endmodule

// File: tb/tb_dpram_initiator.sv
module tb_dpram_initiator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dpram_initiator_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) intf ();

  logic        ram_sel, ram_wr, ram_ready;
  logic [7:0]  ram_addr_a, ram_addr_b;
  logic [15:0] ram_wdata_a, ram_wdata_b, ram_rdata_a, ram_rdata_b;

  dpram_initiator #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .TIMEOUT(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_if        (intf.slave),
    .ram_sel_o     (ram_sel),
    .ram_wr_o      (ram_wr),
    .ram_addr_a_o  (ram_addr_a),
    .ram_addr_b_o  (ram_addr_b),
    .ram_wdata_a_o (ram_wdata_a),
    .ram_wdata_b_o (ram_wdata_b),
    .ram_rdata_a_i (ram_rdata_a),
    .ram_rdata_b_i (ram_rdata_b),
    .ram_ready_i   (ram_ready)
  );

  // RAM model: a read drops ready for one cycle and needs sel held during it.
  logic [15:0] mem [256];
  logic        rdy_q, force_low, init_mem;
  logic [15:0] rda_q, rdb_q;
  int          viol, wr_cnt;

  assign ram_ready   = rdy_q && !force_low;
  assign ram_rdata_a = rda_q;
  assign ram_rdata_b = rdb_q;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h2567;
      rdy_q  <= 1'b1;
      rda_q  <= 16'h0;
      rdb_q  <= 16'h0;
      viol   <= 0;
      wr_cnt <= 0;
    end else if (!rdy_q) begin
      if (!ram_sel && !rst) viol <= viol + 1;
      rdy_q <= 1'b1;
    end else if (ram_sel && ram_ready) begin
      if (ram_wr) begin
        mem[ram_addr_a] <= ram_wdata_a;
        mem[ram_addr_b] <= ram_wdata_b;
        wr_cnt <= wr_cnt + 1;
      end else begin
        rda_q <= mem[ram_addr_a];
        rdb_q <= mem[ram_addr_b];
        rdy_q <= 1'b0;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  // Drives one command from a negedge, counts cycles from the accept edge to
  // the first rsp_valid cycle, completes the handshake and returns at the
  // negedge of the following IDLE cycle.
  task automatic do_cmd(input logic wr, input logic [7:0] aa, input logic [7:0] ab,
                        input logic [15:0] wa, input logic [15:0] wb,
                        output int lat, output logic [15:0] ra, output logic [15:0] rb,
                        output logic er);
    intf.rsp_ready   = 1'b1;
    intf.cmd_valid   = 1'b1;
    intf.cmd_wr      = wr;
    intf.cmd_addr_a  = aa;
    intf.cmd_addr_b  = ab;
    intf.cmd_wdata_a = wa;
    intf.cmd_wdata_b = wb;
    @(posedge clk);
    @(negedge clk);
    intf.cmd_valid = 1'b0;
    lat = 1;
    while (intf.rsp_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (intf.rsp_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", intf.rsp_valid, lat);
    end
    ra = intf.rsp_rdata_a;
    rb = intf.rsp_rdata_b;
    er = intf.rsp_err;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    init_mem = 1'b1;
    repeat (3) @(negedge clk);
    init_mem = 1'b0;
    checks++; if (intf.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b want 0", intf.cmd_ready); end
    checks++; if (intf.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", intf.rsp_valid); end
    checks++; if (ram_sel !== 1'b0 || ram_wr !== 1'b0) begin errors++; $display("FAIL reset_sel_wr: got %b%b want 00", ram_sel, ram_wr); end
    checks++; if (ram_addr_a !== 8'h0 || ram_wdata_b !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h/%h want 0/0", ram_addr_a, ram_wdata_b); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (intf.cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", intf.cmd_ready); end
  endtask

  task automatic test_read_basic();
    int lat; logic [15:0] ra, rb; logic er;
    do_cmd(1'b0, 8'h00, 8'hFF, 16'h0, 16'h0, lat, ra, rb, er);
    checks++; if (lat !== 4) begin errors++; $display("FAIL read_latency: got %0d want 4", lat); end
    checks++; if (ra !== 16'h2567 || rb !== 16'h2567) begin errors++; $display("FAIL read_init: got %h/%h want 2567/2567", ra, rb); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL read_init_err: got %b want 0", er); end
  endtask

  task automatic test_write_read();
    int lat; logic [15:0] ra, rb; logic er;
    do_cmd(1'b1, 8'h10, 8'h20, 16'hBEEF, 16'hCAFE, lat, ra, rb, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL write_latency: got %0d want 2", lat); end
    checks++; if (ra !== 16'h0 || rb !== 16'h0 || er !== 1'b0) begin errors++; $display("FAIL write_rsp: got %h/%h err %b want 0/0 err 0", ra, rb, er); end
    do_cmd(1'b0, 8'h10, 8'h20, 16'h0, 16'h0, lat, ra, rb, er);
    checks++; if (ra !== 16'hBEEF || rb !== 16'hCAFE) begin errors++; $display("FAIL readback: got %h/%h want BEEF/CAFE", ra, rb); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL readback_latency: got %0d want 4", lat); end
  endtask

  task automatic test_rsp_stall();
    int n;
    intf.rsp_ready   = 1'b0;
    intf.cmd_valid   = 1'b1;
    intf.cmd_wr      = 1'b0;
    intf.cmd_addr_a  = 8'h10;
    intf.cmd_addr_b  = 8'h20;
    @(posedge clk);
    @(negedge clk);
    intf.cmd_valid = 1'b0;
    n = 1;
    while (intf.rsp_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++; if (n !== 4) begin errors++; $display("FAIL stall_latency: got %0d want 4", n); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (intf.rsp_valid !== 1'b1 || intf.rsp_rdata_a !== 16'hBEEF || intf.rsp_rdata_b !== 16'hCAFE || intf.cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%b data=%h/%h ready=%b want 1 BEEF/CAFE 0",
                 i, intf.rsp_valid, intf.rsp_rdata_a, intf.rsp_rdata_b, intf.cmd_ready);
      end
      @(negedge clk);
    end
    intf.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (intf.rsp_valid !== 1'b0 || intf.cmd_ready !== 1'b1) begin errors++; $display("FAIL stall_release: valid=%b ready=%b want 0 1", intf.rsp_valid, intf.cmd_ready); end
  endtask

  task automatic test_timeout();
    force_low        = 1'b1;
    intf.rsp_ready   = 1'b1;
    intf.cmd_valid   = 1'b1;
    intf.cmd_wr      = 1'b0;
    intf.cmd_addr_a  = 8'h10;
    intf.cmd_addr_b  = 8'h20;
    @(posedge clk);
    @(negedge clk);
    intf.cmd_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (intf.rsp_valid !== 1'b0 || ram_sel !== 1'b1) begin
        errors++;
        $display("FAIL timeout_wait[%0d]: valid=%b sel=%b want 0 1", c, intf.rsp_valid, ram_sel);
      end
      @(negedge clk);
    end
    checks++; if (intf.rsp_valid !== 1'b1 || intf.rsp_err !== 1'b1) begin errors++; $display("FAIL timeout_rsp: valid=%b err=%b want 1 1", intf.rsp_valid, intf.rsp_err); end
    checks++; if (intf.rsp_rdata_a !== 16'h0 || intf.rsp_rdata_b !== 16'h0) begin errors++; $display("FAIL timeout_rdata: got %h/%h want 0/0", intf.rsp_rdata_a, intf.rsp_rdata_b); end
    checks++; if (ram_sel !== 1'b0) begin errors++; $display("FAIL timeout_sel: got %b want 0", ram_sel); end
    force_low = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (ram_sel !== 1'b0 || intf.cmd_ready !== 1'b1) begin errors++; $display("FAIL timeout_after: sel=%b ready=%b want 0 1", ram_sel, intf.cmd_ready); end
  endtask

  task automatic test_collide();
    int lat; int w0; logic [15:0] ra, rb; logic er;
    w0 = wr_cnt;
    do_cmd(1'b1, 8'h33, 8'h33, 16'h1111, 16'h2222, lat, ra, rb, er);
`ifdef DPRAM_INIT_COLLIDE_CHK_EN
    checks++; if (er !== 1'b1 || lat !== 1) begin errors++; $display("FAIL collide_reject: err=%b lat=%0d want 1 1", er, lat); end
    checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL collide_no_access: writes=%0d want %0d", wr_cnt, w0); end
    do_cmd(1'b0, 8'h33, 8'h33, 16'h0, 16'h0, lat, ra, rb, er);
    checks++; if (ra !== 16'h2567 || rb !== 16'h2567) begin errors++; $display("FAIL collide_read: got %h/%h want 2567/2567", ra, rb); end
`else
    checks++; if (er !== 1'b0 || lat !== 2) begin errors++; $display("FAIL collide_write: err=%b lat=%0d want 0 2", er, lat); end
    checks++; if (wr_cnt !== w0 + 1) begin errors++; $display("FAIL collide_access: writes=%0d want %0d", wr_cnt, w0 + 1); end
    do_cmd(1'b0, 8'h33, 8'h33, 16'h0, 16'h0, lat, ra, rb, er);
    checks++; if (ra !== 16'h2222 || rb !== 16'h2222) begin errors++; $display("FAIL collide_read: got %h/%h want 2222/2222", ra, rb); end
`endif
  endtask

  task automatic test_reset_in_capt();
    int lat; logic [15:0] ra, rb; logic er;
    intf.rsp_ready   = 1'b1;
    intf.cmd_valid   = 1'b1;
    intf.cmd_wr      = 1'b0;
    intf.cmd_addr_a  = 8'h10;
    intf.cmd_addr_b  = 8'h20;
    @(posedge clk);
    @(negedge clk);
    intf.cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (ram_sel !== 1'b1 || ram_ready !== 1'b0) begin errors++; $display("FAIL capt_phase: sel=%b ready=%b want 1 0", ram_sel, ram_ready); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (intf.rsp_valid !== 1'b0 || intf.cmd_ready !== 1'b0 || ram_sel !== 1'b0) begin errors++; $display("FAIL capt_rst: valid=%b ready=%b sel=%b want 0 0 0", intf.rsp_valid, intf.cmd_ready, ram_sel); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (intf.cmd_ready !== 1'b1 || intf.rsp_valid !== 1'b0) begin errors++; $display("FAIL capt_after_rst: ready=%b valid=%b want 1 0", intf.cmd_ready, intf.rsp_valid); end
    do_cmd(1'b0, 8'h10, 8'h20, 16'h0, 16'h0, lat, ra, rb, er);
    checks++; if (ra !== 16'hBEEF || rb !== 16'hCAFE || er !== 1'b0 || lat !== 4) begin errors++; $display("FAIL capt_next_read: got %h/%h err %b lat %0d want BEEF/CAFE 0 4", ra, rb, er, lat); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [15:0] ra, rb; logic er;
    do_cmd(1'b1, 8'h50, 8'h51, 16'hAAAA, 16'h5555, lat, ra, rb, er);
    checks++; if (intf.cmd_ready !== 1'b1 || ram_addr_a !== 8'h0 || ram_wdata_a !== 16'h0) begin errors++; $display("FAIL b2b_idle: ready=%b addr=%h wdata=%h want 1 00 0000", intf.cmd_ready, ram_addr_a, ram_wdata_a); end
    do_cmd(1'b0, 8'h50, 8'h51, 16'h0, 16'h0, lat, ra, rb, er);
    checks++; if (ra !== 16'hAAAA || rb !== 16'h5555 || lat !== 4) begin errors++; $display("FAIL b2b_read: got %h/%h lat %0d want AAAA/5555 4", ra, rb, lat); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL sel_recovery: violations=%0d want 0", viol); end
  endtask

  initial begin
    force_low        = 1'b0;
    init_mem         = 1'b1;
    intf.cmd_valid   = 1'b0;
    intf.cmd_wr      = 1'b0;
    intf.cmd_addr_a  = 8'h0;
    intf.cmd_addr_b  = 8'h0;
    intf.cmd_wdata_a = 16'h0;
    intf.cmd_wdata_b = 16'h0;
    intf.rsp_ready   = 1'b1;
    @(negedge clk);
    test_reset();
    test_read_basic();
    test_write_read();
    test_rsp_stall();
    test_timeout();
    test_collide();
    test_reset_in_capt();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
